// File: rtl/rnn_cell_engine.sv
// rnn_cell_engine: memory-mapped Elman RNN step engine.
//   h' = act(Wx*x + Wh*h + b), y = sat(d.h' + db)
// One signed multiply-accumulate per cycle. The hidden state is double
// buffered, so each row reads the old h while h_next is being filled.
// Build option: define RNN_HARDTANH_EN to use a hard-tanh activation
// clamped to +/-1.0. Without it the activation is linear, with DATA_W
// saturation only. The y output never goes through the activation.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start, tensors writable
// ROW_INIT | acc = b[r] scaled to product precision
// MAC_X    | acc += Wx[r][c]*x[c], IN_LEN cycles
// MAC_H    | acc += Wh[r][c]*h[c] using old h, HID_LEN cycles
// ROW_WB   | h_next[r] = act(sat(acc)), next row or SWAP
// SWAP     | h <= h_next
// D_INIT   | acc = db scaled to product precision
// D_MAC    | acc += d[c]*h[c], HID_LEN cycles
// D_WB     | y <= sat(acc)
// DONE     | result valid, tensors writable
module rnn_cell_engine #(
  parameter int IN_LEN    = 2,
  parameter int HID_LEN   = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out
);

  localparam int ACC_W = 2*DATA_W + $clog2(IN_LEN + HID_LEN + 1);
  localparam int XW    = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
  localparam int HW    = (HID_LEN > 1) ? $clog2(HID_LEN) : 1;
  localparam int CW    = (XW > HW) ? XW : HW;

  localparam logic [8:0]    IN_LIM     = 9'(IN_LEN);
  localparam logic [8:0]    HID_LIM    = 9'(HID_LEN);
  localparam logic [CW-1:0] COL_X_LAST = CW'(IN_LEN - 1);
  localparam logic [CW-1:0] COL_H_LAST = CW'(HID_LEN - 1);
  localparam logic [HW-1:0] ROW_LAST   = HW'(HID_LEN - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [3:0] {
    S_IDLE, S_ROW_INIT, S_MAC_X, S_MAC_H, S_ROW_WB,
    S_SWAP, S_D_INIT, S_D_MAC, S_D_WB, S_DONE
  } state_t;

  state_t r_state, w_next_state;

  logic signed [DATA_W-1:0] r_x      [IN_LEN];
  logic signed [DATA_W-1:0] r_wx     [HID_LEN][IN_LEN];
  logic signed [DATA_W-1:0] r_wh     [HID_LEN][HID_LEN];
  logic signed [DATA_W-1:0] r_b      [HID_LEN];
  logic signed [DATA_W-1:0] r_d      [HID_LEN];
  logic signed [DATA_W-1:0] r_db;
  logic signed [DATA_W-1:0] r_h      [HID_LEN];
  logic signed [DATA_W-1:0] r_h_next [HID_LEN];
  logic signed [DATA_W-1:0] r_y;
  logic        [7:0]        r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [HW-1:0]     r_row;
  logic        [CW-1:0]     r_col;

  logic                       w_busy, w_done, w_cfg_ok;
  logic                       w_ctrl_wr, w_start, w_clear;
  logic        [7:0]          w_row, w_col;
  logic                       w_row_ok, w_colx_ok, w_colh_ok;
  logic signed [DATA_W-1:0]   w_val;
  logic signed [DATA_W-1:0]   w_op_a, w_op_b;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_shift, w_b_ext, w_db_ext;
  logic        [31:0]         w_rd_data;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

`ifdef RNN_HARDTANH_EN
  localparam logic signed [DATA_W-1:0] HT_MAX = DATA_W'(1 << FRAC_BITS);
  localparam logic signed [DATA_W-1:0] HT_MIN = -HT_MAX;
  function automatic logic signed [DATA_W-1:0] act(input logic signed [DATA_W-1:0] v);
    if (v > HT_MAX)      return HT_MAX;
    else if (v < HT_MIN) return HT_MIN;
    else                 return v;
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] act(input logic signed [DATA_W-1:0] v);
    return v;
  endfunction
`endif

  // bus decode: CTRL strobes, index fields and range checks
  always_comb begin
    w_cfg_ok  = (r_state == S_IDLE) || (r_state == S_DONE);
    w_ctrl_wr = i_write && (i_addr == 32'd0);
    w_start   = w_ctrl_wr && i_data_in[0];
    w_clear   = w_ctrl_wr && i_data_in[1];
    w_row     = i_data_in[31:24];
    w_col     = i_data_in[23:16];
    w_val     = i_data_in[DATA_W-1:0];
    w_row_ok  = {1'b0, w_row} < HID_LIM;
    w_colx_ok = {1'b0, w_col} < IN_LIM;
    w_colh_ok = {1'b0, w_col} < HID_LIM;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_next_state = S_ROW_INIT;
      S_ROW_INIT: w_next_state = S_MAC_X;
      S_MAC_X:    if (r_col == COL_X_LAST) w_next_state = S_MAC_H;
      S_MAC_H:    if (r_col == COL_H_LAST) w_next_state = S_ROW_WB;
      S_ROW_WB:   w_next_state = (r_row == ROW_LAST) ? S_SWAP : S_ROW_INIT;
      S_SWAP:     w_next_state = S_D_INIT;
      S_D_INIT:   w_next_state = S_D_MAC;
      S_D_MAC:    if (r_col == COL_H_LAST) w_next_state = S_D_WB;
      S_D_WB:     w_next_state = S_DONE;
      S_DONE: begin
        if (w_start)      w_next_state = S_ROW_INIT;
        else if (w_clear) w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: status flags
  always_comb begin
    w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    w_done = (r_state == S_DONE);
  end

  // MAC operand select and scaled accumulator seeds
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      S_MAC_X: begin
        w_op_a = r_wx[r_row][r_col[XW-1:0]];
        w_op_b = r_x[r_col[XW-1:0]];
      end
      S_MAC_H: begin
        w_op_a = r_wh[r_row][r_col[HW-1:0]];
        w_op_b = r_h[r_col[HW-1:0]];
      end
      S_D_MAC: begin
        w_op_a = r_d[r_col[HW-1:0]];
        w_op_b = r_h[r_col[HW-1:0]];
      end
      default: ;
    endcase
    w_prod   = w_op_a * w_op_b;
    w_shift  = r_acc >>> FRAC_BITS;
    w_b_ext  = ACC_W'(r_b[r_row]);
    w_db_ext = ACC_W'(r_db);
  end

  // tensor register file; writes are dropped while a step is running
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x   <= '{default: '0};
      r_wx  <= '{default: '0};
      r_wh  <= '{default: '0};
      r_b   <= '{default: '0};
      r_d   <= '{default: '0};
      r_db  <= '0;
      r_idx <= '0;
    end else begin
      if (i_write && w_cfg_ok) begin
        case (i_addr)
          32'd1: if (w_colx_ok)             r_x[w_col[XW-1:0]] <= w_val;
          32'd2: if (w_row_ok && w_colx_ok) r_wx[w_row[HW-1:0]][w_col[XW-1:0]] <= w_val;
          32'd3: if (w_row_ok && w_colh_ok) r_wh[w_row[HW-1:0]][w_col[HW-1:0]] <= w_val;
          32'd4: if (w_row_ok)              r_b[w_row[HW-1:0]] <= w_val;
          32'd5: if (w_colh_ok)             r_d[w_col[HW-1:0]] <= w_val;
          32'd6:                            r_db <= w_val;
          default: ;
        endcase
      end
      if (i_write && (i_addr == 32'd8)) r_idx <= w_col;
    end
  end

  // sequencer datapath: counters, accumulator, hidden state and y
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_h      <= '{default: '0};
      r_h_next <= '{default: '0};
      r_y      <= '0;
    end else begin
      // clear lands before the first row reads h when start comes with it
      if (w_clear && w_cfg_ok) begin
        r_h      <= '{default: '0};
        r_h_next <= '{default: '0};
      end
      case (r_state)
        S_IDLE, S_DONE: if (w_start) begin
          r_row <= '0;
          r_col <= '0;
        end
        S_ROW_INIT: begin
          r_acc <= w_b_ext <<< FRAC_BITS;
          r_col <= '0;
        end
        S_MAC_X: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_col <= (r_col == COL_X_LAST) ? '0 : r_col + 1'b1;
        end
        S_MAC_H: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_col <= (r_col == COL_H_LAST) ? '0 : r_col + 1'b1;
        end
        S_ROW_WB: begin
          r_h_next[r_row] <= act(sat(w_shift));
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end
        S_SWAP:   r_h <= r_h_next;
        S_D_INIT: begin
          r_acc <= w_db_ext <<< FRAC_BITS;
          r_col <= '0;
        end
        S_D_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_col <= (r_col == COL_H_LAST) ? '0 : r_col + 1'b1;
        end
        S_D_WB:   r_y <= sat(w_shift);
        default: ;
      endcase
    end
  end

  // read mux, values sign-extended to the bus width
  always_comb begin
    w_rd_data = '0;
    case (i_addr)
      32'd0: w_rd_data = {30'd0, w_done, w_busy};
      32'd7: w_rd_data = 32'(r_y);
      32'd8: if ({1'b0, r_idx} < HID_LIM) w_rd_data = 32'(r_h[r_idx[HW-1:0]]);
      default: ;
    endcase
  end

  // registered read data, holds when no read is sampled
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    o_data_out <= '0;
    else if (i_read) o_data_out <= w_rd_data;
  end

endmodule

// File: tb/tb_rnn_cell_engine.sv
// tb_rnn_cell_engine: directed bench for rnn_cell_engine at default parameters.
// Bus reads push their expected value onto a scoreboard queue; the value is
// popped and compared once the registered read data appears.
module tb_rnn_cell_engine;

  localparam int IN_LEN  = 2;
  localparam int HID_LEN = 4;
  localparam int L       = HID_LEN*(IN_LEN + HID_LEN + 2) + HID_LEN + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_s, wr_s;
  logic [31:0] addr, din;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  rnn_cell_engine #(.IN_LEN(IN_LEN), .HID_LEN(HID_LEN), .DATA_W(16), .FRAC_BITS(8)) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_read     (rd_s),
    .i_write    (wr_s),
    .i_addr     (addr),
    .i_data_in  (din),
    .o_data_out (dout)
  );

  function automatic logic [31:0] pk(input int row, input int col, input logic [15:0] v);
    return {row[7:0], col[7:0], v};
  endfunction

  task automatic expect_v(input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_pop();
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=none", dout);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (dout === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", t, dout, e);
      end
    end
  endtask

  // all tasks start and end on a falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_s = 1'b1; addr = a; din = d;
    @(negedge clk);
    wr_s = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    rd_s = 1'b1; addr = a;
    expect_v(e, t);
    @(negedge clk);
    rd_s = 1'b0;
    check_pop();
  endtask

  task automatic rd_h(input int idx, input logic [31:0] e, input string t);
    wr(32'd8, pk(0, idx, 16'h0));
    rd(32'd8, e, t);
  endtask

  // start a step and check busy on the last busy cycle and done right after;
  // optionally poke a Wx write and a second start while busy
  task automatic run_step(input logic [31:0] ctrl, input bit poke);
    wr_s = 1'b1; addr = 32'd0; din = ctrl;
    @(negedge clk);
    wr_s = 1'b0;
    if (poke) begin
      repeat (4) @(negedge clk);
      wr_s = 1'b1; addr = 32'd2; din = pk(0, 0, 16'h1234);
      @(negedge clk);
      addr = 32'd0; din = 32'd1;
      @(negedge clk);
      wr_s = 1'b0;
      repeat (L - 7) @(negedge clk);
    end else begin
      repeat (L - 1) @(negedge clk);
    end
    rd_s = 1'b1; addr = 32'd0;
    expect_v(32'h1, "lat_busy");
    @(negedge clk);
    check_pop();
    expect_v(32'h2, "lat_done");
    @(negedge clk);
    check_pop();
    rd_s = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_s = 1'b0; wr_s = 1'b0; addr = '0; din = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    rd(32'd0, 32'h0, "rst_status");
    rd(32'd7, 32'h0, "rst_y");
    for (int i = 0; i < HID_LEN; i++) rd_h(i, 32'h0, "rst_h");

    // basic step with out-of-range writes and a busy-time poke
    wr(32'd1, pk(0, 0, 16'h0100));
    wr(32'd2, pk(0, 0, 16'h0080));
    wr(32'd5, pk(0, 0, 16'h0200));
    wr(32'd2, pk(4, 0, 16'h7FFF));
    wr(32'd2, pk(0, 2, 16'h7FFF));
    wr(32'd1, pk(0, 2, 16'h7FFF));
    wr(32'd4, pk(4, 0, 16'h0100));
    wr(32'd5, pk(0, 4, 16'h7FFF));
    run_step(32'd1, 1'b1);
    rd_h(0, 32'h0000_0080, "basic_h0");
    rd_h(1, 32'h0, "basic_h1");
    rd_h(4, 32'h0, "h_idx_oob");
    rd(32'd7, 32'h0000_0100, "basic_y");
    rd(32'd3, 32'h0, "unmapped_rd");

    // read and write in the same cycle return the pre-write index
    wr(32'd8, pk(0, 0, 16'h0));
    rd_s = 1'b1; wr_s = 1'b1; addr = 32'd8; din = pk(0, 1, 16'h0);
    expect_v(32'h0000_0080, "rw_same_cycle");
    @(negedge clk);
    rd_s = 1'b0; wr_s = 1'b0;
    check_pop();
    rd(32'd8, 32'h0, "rw_after");

    // recurrence keeps h0, then clear zeroes it
    wr(32'd1, pk(0, 0, 16'h0000));
    wr(32'd3, pk(0, 0, 16'h0100));
    run_step(32'd1, 1'b0);
    rd_h(0, 32'h0000_0080, "recur_h0");
    rd(32'd7, 32'h0000_0100, "recur_y");
    wr(32'd0, 32'd2);
    rd(32'd0, 32'h0, "clr_status");
    rd_h(0, 32'h0, "clr_h0");

    // negative values and truncation toward -inf, with db
    wr(32'd1, pk(0, 0, 16'h0080));
    wr(32'd2, pk(0, 0, 16'hFFFF));
    wr(32'd6, pk(0, 0, 16'h0010));
    run_step(32'd1, 1'b0);
    rd_h(0, 32'hFFFF_FFFF, "neg_h0");
    rd(32'd7, 32'h0000_000E, "neg_y");
    run_step(32'd1, 1'b0);
    rd_h(0, 32'hFFFF_FFFE, "seq_h0");
    rd(32'd7, 32'h0000_000C, "seq_y");
    run_step(32'd3, 1'b0);
    rd_h(0, 32'hFFFF_FFFF, "clrstart_h0");
    rd(32'd7, 32'h0000_000E, "clrstart_y");

    // saturation
    wr(32'd0, 32'd2);
    wr(32'd6, pk(0, 0, 16'h0000));
    wr(32'd2, pk(0, 0, 16'h7FFF));
    wr(32'd1, pk(0, 0, 16'h0100));
    run_step(32'd1, 1'b0);
`ifdef RNN_HARDTANH_EN
    rd_h(0, 32'h0000_0100, "sat_h0");
    rd(32'd7, 32'h0000_0200, "sat_y");
`else
    rd_h(0, 32'h0000_7FFF, "sat_h0");
    rd(32'd7, 32'h0000_7FFF, "sat_y");
`endif

    // reset in the middle of a step
    wr_s = 1'b1; addr = 32'd0; din = 32'd1;
    @(negedge clk);
    wr_s = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'd0, 32'h0, "midrst_status");
    rd(32'd7, 32'h0, "midrst_y");
    rd_h(0, 32'h0, "midrst_h0");
    run_step(32'd1, 1'b0);
    rd(32'd7, 32'h0, "postrst_y");
    rd_h(0, 32'h0, "postrst_h0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
